// File: rtl/sigma_delta_1st_order.sv
// sigma_delta_1st_order: first-order sigma-delta modulator with an optional sinc3 monitor.
// Define SIGMA_DELTA_SINC3_MON_EN to add the monOut/monValid decimating monitor.
module sigma_delta_1st_order #(
  parameter int WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int OSR = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     in,
  output logic [OUT_WIDTH-1:0]        sdOut
`ifdef SIGMA_DELTA_SINC3_MON_EN
  ,
  output logic [3*$clog2(OSR):0]      monOut,
  output logic                        monValid
`endif
);
  if (OUT_WIDTH < 1 || OUT_WIDTH >= WIDTH || OSR < 2 || (OSR & (OSR - 1)) != 0) begin : g_bad_param
    $error("sigma_delta_1st_order: illegal parameter combination");
  end
  logic [WIDTH-1:0] u, res_q, res_d;
  logic [WIDTH+OUT_WIDTH-1:0] sum;
  logic [OUT_WIDTH-1:0] sd_out_q, sd_out_d;
  // u*(2^OUT_WIDTH-1) as a shift minus the operand; the sum can never overflow
  always_comb begin
    u = {~in[WIDTH-1], in[WIDTH-2:0]};
    sum = {{OUT_WIDTH{1'b0}}, res_q} + {u, {OUT_WIDTH{1'b0}}} - {{OUT_WIDTH{1'b0}}, u};
    sd_out_d = en ? sum[WIDTH+OUT_WIDTH-1:WIDTH] : sd_out_q;
    res_d = en ? sum[WIDTH-1:0] : res_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_out_q <= '0;
      res_q <= '0;
    end else begin
      sd_out_q <= sd_out_d;
      res_q <= res_d;
    end
  end
  assign sdOut = sd_out_q;
`ifdef SIGMA_DELTA_SINC3_MON_EN
  localparam int DW = $clog2(OSR);
  localparam int MW = 3 * DW + 1;
  logic [MW-1:0] i1_q, i2_q, i3_q, d1_q, d2_q, d3_q, mon_q;
  logic [MW-1:0] i1_d, i2_d, i3_d, d1_d, d2_d, d3_d, mon_d;
  logic [MW-1:0] c1, c2, c3;
  logic [DW-1:0] cnt_q, cnt_d;
  logic vld_q, vld_d, dec;
  // wrap-around arithmetic is exact as long as the result fits MW bits
  always_comb begin
    dec = en && (&cnt_q);
    c1 = i3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;
    i1_d = en ? i1_q + MW'(sd_out_q[OUT_WIDTH-1]) : i1_q;
    i2_d = en ? i2_q + i1_q : i2_q;
    i3_d = en ? i3_q + i2_q : i3_q;
    cnt_d = en ? cnt_q + DW'(1) : cnt_q;
    d1_d = dec ? i3_q : d1_q;
    d2_d = dec ? c1 : d2_q;
    d3_d = dec ? c2 : d3_q;
    mon_d = dec ? c3 : mon_q;
    vld_d = en ? dec : vld_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1_q <= '0;
      i2_q <= '0;
      i3_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
      mon_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      i1_q <= i1_d;
      i2_q <= i2_d;
      i3_q <= i3_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      d3_q <= d3_d;
      mon_q <= mon_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end
  assign monOut = mon_q;
  assign monValid = vld_q;
`endif
endmodule

// File: tb/tb_sigma_delta_1st_order.sv
// tb_sigma_delta_1st_order: randomized check of 8-bit and 1-bit modulators against an arithmetic model.
module tb_sigma_delta_1st_order;
  logic clk = 1'b0;
  logic rst, en;
  logic signed [15:0] in;
  logic [7:0] sd8;
  logic [0:0] sd1;
  int tests = 0;
  int fails = 0;
`ifdef SIGMA_DELTA_SINC3_MON_EN
  logic [15:0] mon8, mon1;
  logic mv8, mv1;
`endif
  always #5 clk = ~clk;
  sigma_delta_1st_order #(.WIDTH(16), .OUT_WIDTH(8), .OSR(32)) dut8 (
    .clk(clk), .rst(rst), .en(en), .in(in), .sdOut(sd8)
`ifdef SIGMA_DELTA_SINC3_MON_EN
    , .monOut(mon8), .monValid(mv8)
`endif
  );
  sigma_delta_1st_order #(.WIDTH(16), .OUT_WIDTH(1), .OSR(32)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in(in), .sdOut(sd1)
`ifdef SIGMA_DELTA_SINC3_MON_EN
    , .monOut(mon1), .monValid(mv1)
`endif
  );
  task automatic chk(input string n, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  // reference: code = floor((res + u*(2^N-1)) / 2^16), residue = remainder
  longint r8, r1, uu;
  longint e8, e1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r8 = 0; r1 = 0; e8 = 0; e1 = 0;
    end else if (en) begin
      uu = longint'(in) + 32768;
      r8 = r8 + uu * 255;
      e8 = r8 / 65536;
      r8 = r8 % 65536;
      r1 = r1 + uu;
      e1 = r1 / 65536;
      r1 = r1 % 65536;
    end
  end
  always @(negedge clk) begin
    chk("sd8_vs_model", longint'(sd8), e8);
    chk("sd1_vs_model", longint'(sd1), e1);
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(input logic signed [15:0] v);
    rst = 1'b1;
    en = 1'b1;
    in = v;
    step(2);
    chk("reset_sd8", longint'(sd8), 0);
    rst = 1'b0;
  endtask
`ifdef SIGMA_DELTA_SINC3_MON_EN
  task automatic mon_run(input logic signed [15:0] v, input int lo, input int hi, input string n);
    int last, np;
    last = -1;
    np = 0;
    do_reset(v);
    for (int k = 0; k < 32 * 10; k++) begin
      step();
      if (mv1) begin
        if (last >= 0) chk("mon_period", k - last, 32);
        last = k;
        np++;
        if (np >= 6) chk(n, longint'(mon1 >= lo && mon1 <= hi), 1);
      end
    end
    chk("mon_pulses", np, 10);
  endtask
`endif
  initial begin
    int s;
    int ref_seq[30];
    int got[$];
    logic [7:0] held;
    rst = 1'b1;
    en = 1'b0;
    in = '0;
    step();
    do_reset(16'sd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("sd1_alt", longint'(sd1), k % 2);
      chk("sd8_alt", longint'(sd8), (k % 2) ? 128 : 127);
    end
    do_reset(-16'sd32768);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("sd8_neg_fs", longint'(sd8), 0);
    end
    do_reset(16'sd32767);
    step();
    chk("sd1_pos_fs_first", longint'(sd1), 0);
    for (int k = 0; k < 200; k++) begin
      step();
      chk("sd1_pos_fs_ones", longint'(sd1), 1);
    end
    do_reset(16'sd16384);
    s = 0;
    for (int k = 0; k < 1024; k++) begin
      step();
      s += int'(sd1);
    end
    chk("sd1_mean_0p75", longint'(s >= 767 && s <= 769), 1);
    do_reset(16'sd12345);
    for (int k = 0; k < 30; k++) begin
      step();
      ref_seq[k] = int'(sd8);
    end
    do_reset(16'sd12345);
    for (int k = 0; k < 5; k++) begin
      step();
      got.push_back(int'(sd8));
    end
    en = 1'b0;
    held = sd8;
    for (int k = 0; k < 10; k++) begin
      in = 16'($urandom);
      step();
      chk("hold_frozen", longint'(sd8), longint'(held));
    end
    in = 16'sd12345;
    en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      got.push_back(int'(sd8));
    end
    for (int k = 0; k < 30; k++) chk("hold_shifted_seq", got[k], ref_seq[k]);
    step(3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_sd8", longint'(sd8), 0);
    step();
    rst = 1'b0;
    step();
    chk("restart_first_code", longint'(sd8), 175);
    for (int k = 0; k < 3000; k++) begin
      in = 16'($urandom);
      en = ($urandom % 8) != 0;
      rst = ($urandom % 200) == 0;
      step();
    end
    rst = 1'b0;
    en = 1'b1;
`ifdef SIGMA_DELTA_SINC3_MON_EN
    mon_run(16'sd32767, 32767, 32768, "mon_pos_fs");
    mon_run(-16'sd32768, 0, 0, "mon_neg_fs");
    mon_run(16'sd0, 16352, 16416, "mon_mid");
`endif
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sigma_delta_1st_order.md
SIGMA_DELTA_1ST_ORDER -- requirements
Module: sigma_delta_1st_order

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the input word width in bits (two's complement).
REQ-002 The block SHALL have parameter OUT_WIDTH, default 8, giving the output code width; legal range is 1 to WIDTH-1.
REQ-003 The block SHALL have parameter OSR, default 32, giving the monitor decimation ratio; it SHALL be a power of two and at least 2, and is used only when SIGMA_DELTA_SINC3_MON_EN is defined.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 en  input  1  clock enable; state advances only on rising edges with en=1.
REQ-007 in  input  WIDTH  signed two's-complement sample, sampled on enabled edges.
REQ-008 sdOut  output  OUT_WIDTH  unsigned offset-binary modulator code, registered.
REQ-009 monOut  output  3*log2(OSR)+1  sinc3 monitor result, registered; present only with SIGMA_DELTA_SINC3_MON_EN.
REQ-010 monValid  output  1  one-enabled-cycle strobe marking a new monOut value; present only with SIGMA_DELTA_SINC3_MON_EN.

Function
REQ-011 The block SHALL convert in to unsigned u = in + 2^(WIDTH-1) by inverting the MSB, so that -2^(WIDTH-1) maps to 0 and 2^(WIDTH-1)-1 maps to 2^WIDTH-1.
REQ-012 The block SHALL hold a WIDTH-bit residue register res.
REQ-013 On each enabled edge the block SHALL compute sum = res + u*(2^OUT_WIDTH-1) in WIDTH+OUT_WIDTH bits, where the product is formed as (u<<OUT_WIDTH)-u with no multiplier.
REQ-014 On each enabled edge the block SHALL load sdOut with sum[WIDTH+OUT_WIDTH-1:WIDTH] and load res with sum[WIDTH-1:0].
REQ-015 sum SHALL never exceed 2^(WIDTH+OUT_WIDTH)-1, so no saturation or overflow logic is required.
REQ-016 The long-run mean of sdOut SHALL equal u*(2^OUT_WIDTH-1)/2^WIDTH; the quantization error SHALL be first-order noise-shaped.
REQ-017 Latency SHALL be one enabled cycle from an in sample to the sdOut code it affects.
REQ-018 When OUT_WIDTH=1 the block SHALL reduce to the classic accumulator-carry modulator: sdOut is the carry of res+u.
REQ-019 With en=0, sdOut, res and all monitor state SHALL hold their values.
REQ-020 An asserted in value SHALL be used as-is; there are no handshake or valid inputs.

Reset
REQ-021 While rst=1, res SHALL be 0 and sdOut SHALL be 0, independent of clk and en.
REQ-022 While rst=1, all monitor integrators, combs, the decimation counter, monOut and monValid SHALL be 0.
REQ-023 A reset asserted mid-operation SHALL discard the residue; the first enabled edge after release SHALL compute sum = 0 + u*(2^OUT_WIDTH-1).

Configuration
REQ-024 With macro SIGMA_DELTA_SINC3_MON_EN defined, the block SHALL include a sinc3 decimating monitor whose input is sdOut[OUT_WIDTH-1] (0 or 1).
REQ-025 The monitor SHALL use three cascaded integrators updated every enabled cycle, all in modulo-2^(3*log2(OSR)+1) arithmetic.
REQ-026 The monitor SHALL use a decimation counter that, every OSR enabled cycles, feeds the third integrator into three cascaded differentiators of delay 1 (decimated rate).
REQ-027 On each decimated update the monitor SHALL register the differentiator result into monOut and pulse monValid for one enabled cycle.
REQ-028 The monitor DC gain SHALL be OSR^3: a constant-1 input yields monOut=OSR^3 (32768 for OSR=32), and a constant-0 input yields 0, from the third decimated output onward.
REQ-029 Without SIGMA_DELTA_SINC3_MON_EN, the monitor logic, the monOut and monValid ports, and OSR usage SHALL be absent, and modulator behaviour SHALL be identical.

Verification
REQ-030 WIDTH=16, OUT_WIDTH=1, in=0 after reset -> sdOut sequence 0,1,0,1,... from the first enabled edge.
REQ-031 WIDTH=16, OUT_WIDTH=8, in=0 -> sdOut alternates 127,128 (first 127); in=-32768 -> sdOut constantly 0.
REQ-032 WIDTH=16, OUT_WIDTH=1, in=32767 -> first code 0, then 65535 consecutive 1s, then one 0; in=16384 -> mean 0.75 over 1024 cycles within +-1 count.
REQ-033 Hold en=0 for 10 cycles mid-stream -> sdOut and residue are frozen; resuming reproduces the same sequence shifted by 10 cycles; rst pulse mid-stream -> sdOut=0 immediately (asynchronous) and restarts per REQ-023.
REQ-034 With SIGMA_DELTA_SINC3_MON_EN, OSR=32, OUT_WIDTH=1: in=32767 -> monOut settles to 32767 or 32768; in=-32768 -> 0; in=0 -> 16384+-32; monValid every 32 enabled cycles.
REQ-035 Swept full-scale sine (chirp) on in with the monitor enabled -> monOut tracks in with no wrap discontinuities over 2^18 samples.
